// File: rtl/btn_svc_pkg.sv
// Shared types and constants for the button IRQ servicer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_svc_pkg;

  typedef enum logic [3:0] {
    S_INIT_MASK,
    S_IDLE,
    S_RD_EDGE,
    S_RD_WAIT,
    S_CLR_EDGE,
    S_MASK_OFF,
    S_HOLD,
    S_CLR_BOUNCE,
    S_RD_LVL,
    S_RD_LVL_WAIT,
    S_REARM
  } state_t;

  // PIO register offsets
  localparam logic [1:0] PIO_DATA     = 2'd0;
  localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

  // One Avalon-MM master cycle as driven onto the bus.
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  // Hold-off counter width; never below one bit so a zero window still elaborates.
  function automatic int hold_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Bus cycle issued while the FSM sits in a given state.
  function automatic bus_t bus_decode(input state_t s);
    bus_t b;
    b = '{cs: 1'b0, write_n: 1'b1, addr: 2'd0, wdata: 32'd0};
    case (s)
      S_INIT_MASK:  b = '{cs: 1'b1, write_n: 1'b0, addr: PIO_IRQ_MASK, wdata: 32'd1};
      S_RD_EDGE:    b = '{cs: 1'b1, write_n: 1'b1, addr: PIO_EDGE_CAP, wdata: 32'd0};
      S_CLR_EDGE:   b = '{cs: 1'b1, write_n: 1'b0, addr: PIO_EDGE_CAP, wdata: 32'd1};
      S_MASK_OFF:   b = '{cs: 1'b1, write_n: 1'b0, addr: PIO_IRQ_MASK, wdata: 32'd0};
      S_CLR_BOUNCE: b = '{cs: 1'b1, write_n: 1'b0, addr: PIO_EDGE_CAP, wdata: 32'd1};
      S_RD_LVL:     b = '{cs: 1'b1, write_n: 1'b1, addr: PIO_DATA,     wdata: 32'd0};
      S_REARM:      b = '{cs: 1'b1, write_n: 1'b0, addr: PIO_IRQ_MASK, wdata: 32'd1};
      default:      b = '{cs: 1'b0, write_n: 1'b1, addr: 2'd0,         wdata: 32'd0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/btn_holdoff_timer.sv
// Load/count-down timer that times the IRQ-masked debounce window.
// Latency: done asserts HOLDOFF_CYCLES run cycles after load.
// Backpressure: none; counts only while run_i is high.
module btn_holdoff_timer
  import btn_svc_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic done_o
);

  localparam int W = hold_cnt_w(HOLDOFF_CYCLES);
  // Loading N-1 and finishing at zero gives exactly N cycles in the hold state.
  localparam logic [W-1:0] LOAD_VAL = W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload on entry, otherwise decrement towards zero while running.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/btn_irq_servicer.sv
// Avalon-MM master servicing a button PIO: counts presses, debounces by masking the IRQ.
// Latency: 9+HOLDOFF_CYCLES cycles from an accepted IRQ back to IDLE; bus outputs registered.
// Backpressure: none on the bus (no waitrequest); enable only gates leaving IDLE.
module btn_irq_servicer
  import btn_svc_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 500000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             count_clr,
  input  logic             pio_irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             btn_level,
  output logic             busy
);

  state_t             state_q, state_d;
  logic               armed_q;
  logic               hold_done;
  bus_t               bus_q;
  logic               press_pulse_q;
  logic [CNT_W-1:0]   press_count_q, press_count_d;
  logic               btn_level_q;
  logic               busy_q;
  logic               unused_rd;

  assign unused_rd = ^avm_readdata[31:1];

  btn_holdoff_timer #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (state_q == S_MASK_OFF),
    .run_i  (state_q == S_HOLD),
    .done_o (hold_done)
  );

  // Next-state logic. INIT_MASK lingers one extra cycle after reset so its
  // write, registered from the next state, actually reaches the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_MASK:   state_d = armed_q ? S_IDLE : S_INIT_MASK;
      S_IDLE:        if (pio_irq && enable) state_d = S_RD_EDGE;
      S_RD_EDGE:     state_d = S_RD_WAIT;
      S_RD_WAIT:     state_d = avm_readdata[0] ? S_CLR_EDGE : S_IDLE;
      S_CLR_EDGE:    state_d = S_MASK_OFF;
      S_MASK_OFF:    state_d = (HOLDOFF_CYCLES == 0) ? S_CLR_BOUNCE : S_HOLD;
      S_HOLD:        if (hold_done) state_d = S_CLR_BOUNCE;
      S_CLR_BOUNCE:  state_d = S_RD_LVL;
      S_RD_LVL:      state_d = S_RD_LVL_WAIT;
      S_RD_LVL_WAIT: state_d = S_REARM;
      S_REARM:       state_d = S_IDLE;
      default:       state_d = S_INIT_MASK;
    endcase
  end

  // Press counter: clear wins over an increment landing in the same cycle.
  always_comb begin
    press_count_d = press_count_q;
    if (count_clr) begin
      press_count_d = '0;
    end else if (state_d == S_CLR_EDGE) begin
      press_count_d = press_count_q + CNT_W'(1);
    end
  end

  // State register plus registered outputs, aligned with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT_MASK;
      armed_q       <= 1'b0;
      bus_q         <= '{cs: 1'b0, write_n: 1'b1, addr: 2'd0, wdata: 32'd0};
      press_pulse_q <= 1'b0;
      press_count_q <= '0;
      btn_level_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= 1'b1;
      bus_q         <= bus_decode(state_d);
      press_pulse_q <= (state_d == S_CLR_EDGE);
      press_count_q <= press_count_d;
      busy_q        <= (state_d != S_IDLE);
      if (state_q == S_RD_LVL_WAIT) begin
        btn_level_q <= avm_readdata[0];
      end
    end
  end

  assign avm_chipselect = bus_q.cs;
  assign avm_write_n    = bus_q.write_n;
  assign avm_address    = bus_q.addr;
  assign avm_writedata  = bus_q.wdata;
  assign press_pulse    = press_pulse_q;
  assign press_count    = press_count_q;
  assign btn_level      = btn_level_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_btn_irq_servicer.sv
// Bench for btn_irq_servicer with a behavioural button PIO and a bus scoreboard.
// Latency: expected bus cycles carry their absolute cycle number.
// Backpressure: none modelled; the PIO slave answers every access in one cycle.
module tb_btn_irq_servicer;

  localparam int HOLD  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             count_clr;
  logic             pio_irq;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata = 32'd0;
  logic             press_pulse;
  logic [CNT_W-1:0] press_count;
  logic             btn_level;
  logic             busy;

  // Button PIO model state
  logic btn;
  logic btn_prev = 1'b0;
  logic edge_cap = 1'b0;
  logic mask     = 1'b0;
  logic force_irq;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_item_t;

  bus_item_t sb_q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  btn_irq_servicer #(
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .count_clr     (count_clr),
    .pio_irq       (pio_irq),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .press_pulse   (press_pulse),
    .press_count   (press_count),
    .btn_level     (btn_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave: rising-edge capture, write-1-to-clear edge register, IRQ mask, registered reads.
  always @(posedge clk) begin
    btn_prev <= btn;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
      mask <= avm_writedata[0];
    edge_cap <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3 && avm_writedata[0])
                 ? 1'b0 : edge_cap) | (btn & ~btn_prev);
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 2'd3) ? {31'd0, edge_cap} :
                      (avm_address == 2'd0) ? {31'd0, btn} : 32'd0;
  end

  assign pio_irq = (edge_cap & mask) | force_irq;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int c, input bit wr, input logic [1:0] a, input logic [31:0] d);
    bus_item_t it;
    it.cyc = c; it.wr = wr; it.addr = a; it.data = d;
    sb_q.push_back(it);
  endtask

  // Full service sequence starting from T0 = c0.
  task automatic push_service(input int c0);
    push(c0 + 1,        1'b0, 2'd3, 32'd0);
    push(c0 + 3,        1'b1, 2'd3, 32'd1);
    push(c0 + 4,        1'b1, 2'd2, 32'd0);
    push(c0 + 5 + HOLD, 1'b1, 2'd3, 32'd1);
    push(c0 + 6 + HOLD, 1'b0, 2'd0, 32'd0);
    push(c0 + 8 + HOLD, 1'b1, 2'd2, 32'd1);
  endtask

  // One button press, optionally bouncing in HOLD and clearing the count at the increment edge.
  task automatic press(input bit bounce, input bit keep_btn, input bit clr, input int exp_cnt);
    int c0;
    @(negedge clk);
    btn = 1'b1;
    c0 = cyc + 1;
    push_service(c0);
    wait_to(c0 + 2);
    chk("pulse_T2", press_pulse, 0);
    if (clr) count_clr = 1'b1;
    wait_to(c0 + 3);
    count_clr = 1'b0;
    chk("pulse_T3", press_pulse, 1);
    chk("count_T3", press_count, exp_cnt);
    wait_to(c0 + 4);
    chk("pulse_T4", press_pulse, 0);
    if (!bounce) btn = keep_btn;
    wait_to(c0 + 5);
    if (bounce) btn = 1'b0;
    wait_to(c0 + 6);
    if (bounce) btn = 1'b1;
    wait_to(c0 + 7);
    if (bounce) btn = keep_btn;
    wait_to(c0 + 8 + HOLD);
    chk("busy_rearm", busy, 1);
    chk("btn_level", btn_level, keep_btn);
    wait_to(c0 + 9 + HOLD);
    chk("busy_idle", busy, 0);
    btn = 1'b0;
    wait_to(c0 + 11 + HOLD);
  endtask

  // Monitor: every bus cycle must match the head of the scoreboard.
  initial begin
    bus_item_t it;
    forever begin
      @(negedge clk);
      if (!reset && avm_chipselect) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL bus_unexpected: got access addr %0d write_n %0b at cycle %0d, expected none",
                   avm_address, avm_write_n, cyc);
        end else begin
          it = sb_q.pop_front();
          chk("bus_cycle", cyc, it.cyc);
          chk("bus_is_write", !avm_write_n, it.wr);
          chk("bus_addr", avm_address, it.addr);
          if (it.wr) chk("bus_wdata", avm_writedata, it.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; enable = 1'b1; count_clr = 1'b0; force_irq = 1'b0; btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write_n", avm_write_n, 1);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_count", press_count, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    c0 = cyc;
    push(c0 + 1, 1'b1, 2'd2, 32'd1);
    wait_to(c0 + 2);
    chk("init_busy_low", busy, 0);
    wait_to(c0 + 4);

    // Press with bounce during HOLD; no second service may follow.
    press(1'b1, 1'b1, 1'b0, 1);
    repeat (20) @(negedge clk);
    chk("count_after_bounce", press_count, 1);

    // Spurious IRQ: edge capture reads back 0.
    @(negedge clk);
    force_irq = 1'b1;
    c0 = cyc;
    push(c0 + 1, 1'b0, 2'd3, 32'd0);
    wait_to(c0 + 1);
    force_irq = 1'b0;
    wait_to(c0 + 2);
    chk("spur_busy_T2", busy, 1);
    wait_to(c0 + 3);
    chk("spur_busy_T3", busy, 0);
    chk("spur_pulse", press_pulse, 0);
    chk("spur_count", press_count, 1);
    wait_to(c0 + 10);

    // enable low blocks a new service from IDLE.
    enable = 1'b0;
    force_irq = 1'b1;
    repeat (5) @(negedge clk);
    chk("disabled_busy", busy, 0);
    force_irq = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Clear, then 16 presses wrap the 4-bit counter back to 0.
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    chk("count_cleared", press_count, 0);
    for (int i = 0; i < 16; i++) press(1'b0, i[0], 1'b0, (i + 1) % 16);
    chk("count_wrapped", press_count, 0);

    // Clear coincident with the increment: clear wins.
    press(1'b0, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b1, 0);

    // Reset asserted in HOLD.
    @(negedge clk);
    btn = 1'b1;
    c0 = cyc + 1;
    push_service(c0);
    wait_to(c0 + 5);
    chk("pre_rst_count", press_count, 1);
    chk("pre_rst_cs", avm_chipselect, 0);
    wait_to(c0 + 6);
    reset = 1'b1;
    #1;
    chk("midrst_cs", avm_chipselect, 0);
    chk("midrst_write_n", avm_write_n, 1);
    chk("midrst_count", press_count, 0);
    chk("midrst_busy", busy, 0);
    sb_q.delete();
    btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    push(c0 + 1, 1'b1, 2'd2, 32'd1);
    wait_to(c0 + 2);
    chk("rerst_busy", busy, 0);
    chk("rerst_count", press_count, 0);

    repeat (30) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
